// File: rtl/max_pool_2x2.sv
// ---------------------------------------------------------------------------
// max_pool_2x2
//
// 2x2, stride-2 max pooling over a raster-ordered feature map. Each input
// beat carries all NUM_FILTERS channels of one pixel. Every channel is
// pooled independently with a signed compare. The result can optionally be
// clamped at zero (ReLU). One pooled beat is produced per 2x2 window, one
// cycle after the window's last pixel (odd row, odd column) is accepted.
//
// Ports
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   i_feature_valid  input beat qualifier (gaps allowed)
//   i_features       one pixel, channel k at bits [k*FEATURE_WIDTH +: FEATURE_WIDTH]
//   o_feature_valid  one-cycle pulse per pooled result
//   o_features       pooled result, same channel packing; holds between pulses
//   o_frame_done     pulses with the last pooled beat of a frame
//
// Even rows fill a half-width line buffer with horizontal pair maxima. Odd
// rows combine the buffered pair with the current pair and emit. No
// backpressure: downstream must accept every output beat.
// ---------------------------------------------------------------------------
module max_pool_2x2 #(
  parameter int NUM_FILTERS   = 6,
  parameter int FEATURE_WIDTH = 16,
  parameter int MAP_WIDTH     = 28,
  parameter int MAP_HEIGHT    = 28,
  parameter int RELU          = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_feature_valid,
  input  logic [NUM_FILTERS*FEATURE_WIDTH-1:0] i_features,
  output logic                                 o_feature_valid,
  output logic [NUM_FILTERS*FEATURE_WIDTH-1:0] o_features,
  output logic                                 o_frame_done
);

  localparam int VW    = NUM_FILTERS * FEATURE_WIDTH;
  localparam int CW    = $clog2(MAP_WIDTH);
  localparam int RW    = $clog2(MAP_HEIGHT);
  localparam int DEPTH = MAP_WIDTH / 2;
  localparam int AW    = CW - 1;

  // Position counters, advanced only by accepted beats
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // First pixel of the current horizontal pair
  logic [VW-1:0] hmax_q, hmax_d;

  // Buffered pair maximum of the row above, read one beat ahead
  logic [VW-1:0] line_buf [DEPTH];
  logic [VW-1:0] rd_q;

  logic [VW-1:0] pmax;
  logic [VW-1:0] pool_out;

  logic          valid_q;
  logic          done_q;
  logic [VW-1:0] out_q;

  logic [AW-1:0] buf_addr;
  logic          last_col;
  logic          last_row;
  logic          odd_col;
  logic          emit_row;
  logic          emit_beat;

  assign buf_addr  = col_q[CW-1:1];
  assign last_col  = (col_q == CW'(MAP_WIDTH - 1));
  assign last_row  = (row_q == RW'(MAP_HEIGHT - 1));
  assign odd_col   = col_q[0];
  assign emit_row  = row_q[0];
  assign emit_beat = i_feature_valid && odd_col && emit_row;

  // Counter and pair-register next state
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hmax_d = hmax_q;
    if (i_feature_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!odd_col) begin
        hmax_d = i_features;
      end
    end
  end

  // Per-channel signed compare tree: pair max, then window max, then ReLU
  for (genvar gi = 0; gi < NUM_FILTERS; gi++) begin : gen_ch
    logic signed [FEATURE_WIDTH-1:0] h_s;
    logic signed [FEATURE_WIDTH-1:0] x_s;
    logic signed [FEATURE_WIDTH-1:0] b_s;
    logic signed [FEATURE_WIDTH-1:0] p_s;
    logic signed [FEATURE_WIDTH-1:0] w_s;

    assign h_s = hmax_q[gi*FEATURE_WIDTH +: FEATURE_WIDTH];
    assign x_s = i_features[gi*FEATURE_WIDTH +: FEATURE_WIDTH];
    assign b_s = rd_q[gi*FEATURE_WIDTH +: FEATURE_WIDTH];
    assign p_s = (h_s > x_s) ? h_s : x_s;
    assign w_s = (b_s > p_s) ? b_s : p_s;

    assign pmax[gi*FEATURE_WIDTH +: FEATURE_WIDTH] = p_s;
    assign pool_out[gi*FEATURE_WIDTH +: FEATURE_WIDTH] =
      ((RELU != 0) && w_s[FEATURE_WIDTH-1]) ? '0 : w_s;
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hmax_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hmax_q  <= hmax_d;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (emit_beat) begin
        out_q   <= pool_out;
        valid_q <= 1'b1;
        done_q  <= last_row && last_col;
      end
    end
  end

  // Line buffer with registered read. The read is issued on the even-column
  // beat of an odd row so the data is ready by the pair-completing beat,
  // however many idle cycles separate the two. Writes happen on even rows
  // only, so a read and a write never target the same row.
  always_ff @(posedge clk) begin
    if (i_feature_valid && odd_col && !emit_row) begin
      line_buf[buf_addr] <= pmax;
    end
    if (i_feature_valid && !odd_col && emit_row) begin
      rd_q <= line_buf[buf_addr];
    end
  end

  assign o_feature_valid = valid_q;
  assign o_frame_done    = done_q;
  assign o_features      = out_q;

endmodule
